// File: rtl/boot_loader.sv
// Boot loader: streams program words from an upstream valid/ready source into
// instruction memory, then releases the CPU. Optional macro: BOOT_LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset, waiting for the first load request
// S_LOAD  | accepting program beats and writing them to instruction memory
// S_CHECK | one-cycle verification slot after the final beat
// S_RUN   | program loaded, CPU start held high
// S_ERROR | overflow or checksum failure, waiting for a new load request
module boot_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              data_valid_i,
  input  logic [31:0]       data_i,
  input  logic              data_last_i,
  output logic              data_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] word_count;
  logic            accept;
  logic            wr_beat;
  logic            start_load;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]     csum_acc;
  logic            csum_ok;
`endif

  assign word_count_o = word_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_ready_o = 1'b0;
    start_o      = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    accept       = 1'b0;
    wr_beat      = 1'b0;
    start_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_req_i) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        busy_o       = 1'b1;
        data_ready_o = (word_count < DEPTH_C);
        accept       = data_valid_i && data_ready_o;
        if (accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          // The last beat carries the checksum and never reaches memory.
          if (data_last_i) begin
            state_nxt = S_CHECK;
          end else begin
            wr_beat = 1'b1;
            if (word_count == LAST_C) begin
              state_nxt = S_ERROR;
            end
          end
`else
          wr_beat = 1'b1;
          if (data_last_i) begin
            state_nxt = S_CHECK;
          end else if (word_count == LAST_C) begin
            state_nxt = S_ERROR;
          end
`endif
        end
      end
      S_CHECK: begin
        busy_o = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        state_nxt = csum_ok ? S_RUN : S_ERROR;
`else
        state_nxt = S_RUN;
`endif
      end
      S_RUN: begin
        start_o = 1'b1;
        if (load_req_i) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_ERROR: begin
        err_o = 1'b1;
        if (load_req_i) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Write port and counter update together so the address is the pre-increment count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      word_count  <= '0;
    end else begin
      imem_we_o <= wr_beat;
      if (start_load) begin
        word_count <= '0;
      end else if (wr_beat) begin
        word_count <= word_count + ONE_C;
      end
      if (wr_beat) begin
        imem_addr_o <= word_count[ADDR_W-1:0];
        imem_data_o <= data_i;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csum_acc <= '0;
      csum_ok  <= 1'b0;
    end else begin
      if (start_load) begin
        csum_acc <= '0;
        csum_ok  <= 1'b0;
      end else if (accept && !data_last_i) begin
        csum_acc <= csum_acc + data_i;
      end else if (accept && data_last_i) begin
        csum_ok <= (csum_acc == data_i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; checksum scenarios are
// compiled in when BOOT_LOADER_CHECKSUM_EN is defined.
module tb_boot_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk_i;
  logic              rst_i;
  logic              load_req_i;
  logic              data_valid_i;
  logic [31:0]       data_i;
  logic              data_last_i;
  logic              data_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              start_o;
  logic              busy_o;
  logic              err_o;
  logic [ADDR_W:0]   word_count_o;

  int errors = 0;
  int checks = 0;

  int          n_wr = 0;
  logic [7:0]  wr_addr [0:511];
  logic [31:0] wr_data [0:511];

  logic [31:0] prog [0:2];

  boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_req_i   (load_req_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_last_i  (data_last_i),
    .data_ready_o (data_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .word_count_o (word_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      if (n_wr < 512) begin
        wr_addr[n_wr] = imem_addr_o;
        wr_data[n_wr] = imem_data_o;
      end
      n_wr = n_wr + 1;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    load_req_i = 1'b0;
    data_valid_i = 1'b0;
    data_i = '0;
    data_last_i = 1'b0;
    #12;
    checks++;
    if ({data_ready_o, imem_we_o, start_o, busy_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000", {data_ready_o, imem_we_o, start_o, busy_o, err_o});
    end
    checks++;
    if (word_count_o !== 9'd0 || imem_addr_o !== 8'd0 || imem_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_values count=%0d addr=%0d data=%h exp=0", word_count_o, imem_addr_o, imem_data_o);
    end
    rst_i = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b0 || data_ready_o !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b ready=%b start=%b exp=000", busy_o, data_ready_o, start_o);
    end
  endtask

  task automatic test_basic();
    n_wr = 0;
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || data_ready_o !== 1'b1 || word_count_o !== 9'd0) begin
      errors++;
      $display("FAIL basic_enter busy=%b ready=%b count=%0d exp=1 1 0", busy_o, data_ready_o, word_count_o);
    end
    for (int i = 0; i < 3; i++) begin
      data_valid_i = 1'b1;
      data_i = prog[i];
      data_last_i = (i == 2);
      step();
    end
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
    checks++;
    if (start_o !== 1'b0 || data_ready_o !== 1'b0 || imem_we_o !== 1'b1 || word_count_o !== 9'd3) begin
      errors++;
      $display("FAIL basic_check start=%b ready=%b we=%b count=%0d exp=0 0 1 3", start_o, data_ready_o, imem_we_o, word_count_o);
    end
    step();
    checks++;
    if (start_o !== 1'b1 || busy_o !== 1'b0 || imem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_run start=%b busy=%b we=%b exp=1 0 0", start_o, busy_o, imem_we_o);
    end
    checks++;
    if (n_wr !== 3 || wr_addr[0] !== 8'd0 || wr_addr[1] !== 8'd1 || wr_addr[2] !== 8'd2) begin
      errors++;
      $display("FAIL basic_addr n=%0d addr=%0d,%0d,%0d exp=3 0,1,2", n_wr, wr_addr[0], wr_addr[1], wr_addr[2]);
    end
    checks++;
    if (wr_data[0] !== 32'h00000013 || wr_data[1] !== 32'h00500093 || wr_data[2] !== 32'h00A00113) begin
      errors++;
      $display("FAIL basic_data got=%h,%h,%h", wr_data[0], wr_data[1], wr_data[2]);
    end
    step();
    checks++;
    if (imem_addr_o !== 8'd2 || start_o !== 1'b1 || word_count_o !== 9'd3) begin
      errors++;
      $display("FAIL basic_hold addr=%0d start=%b count=%0d exp=2 1 3", imem_addr_o, start_o, word_count_o);
    end
  endtask

  task automatic test_stall();
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    n_wr = 0;
    checks++;
    if (start_o !== 1'b0 || word_count_o !== 9'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reload_run start=%b count=%0d busy=%b exp=0 0 1", start_o, word_count_o, busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      data_valid_i = 1'b1;
      data_i = prog[i];
      data_last_i = (i == 2);
      step();
      data_valid_i = 1'b0;
      data_last_i = 1'b0;
      data_i = 32'hDEAD_BEEF;
      repeat (4) step();
      checks++;
      if (word_count_o !== 9'(i + 1)) begin
        errors++;
        $display("FAIL stall_count beat=%0d got=%0d exp=%0d", i, word_count_o, i + 1);
      end
    end
    checks++;
    if (start_o !== 1'b1 || n_wr !== 3) begin
      errors++;
      $display("FAIL stall_run start=%b writes=%0d exp=1 3", start_o, n_wr);
    end
    checks++;
    if (wr_addr[2] !== 8'd2 || wr_data[0] !== 32'h00000013 || wr_data[2] !== 32'h00A00113) begin
      errors++;
      $display("FAIL stall_data addr2=%0d d0=%h d2=%h", wr_addr[2], wr_data[0], wr_data[2]);
    end
  endtask

  task automatic test_ignore_req();
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    n_wr = 0;
    data_valid_i = 1'b1;
    data_i = prog[0];
    step();
    data_valid_i = 1'b0;
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    checks++;
    if (word_count_o !== 9'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ignore_req count=%0d busy=%b exp=1 1", word_count_o, busy_o);
    end
    for (int i = 1; i < 3; i++) begin
      data_valid_i = 1'b1;
      data_i = prog[i];
      data_last_i = (i == 2);
      step();
    end
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
    step();
    checks++;
    if (start_o !== 1'b1 || n_wr !== 3 || word_count_o !== 9'd3) begin
      errors++;
      $display("FAIL ignore_done start=%b writes=%0d count=%0d exp=1 3 3", start_o, n_wr, word_count_o);
    end
  endtask

  task automatic test_overflow();
    int bad;
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    n_wr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      data_valid_i = 1'b1;
      data_i = 32'h1000 + 32'(i);
      data_last_i = 1'b0;
      step();
    end
    checks++;
    if (err_o !== 1'b1 || start_o !== 1'b0 || data_ready_o !== 1'b0 || word_count_o !== 9'd256) begin
      errors++;
      $display("FAIL ovf_state err=%b start=%b ready=%b count=%0d exp=1 0 0 256", err_o, start_o, data_ready_o, word_count_o);
    end
    repeat (3) step();
    data_valid_i = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== 32'h1000 + 32'(i)) bad++;
    end
    checks++;
    if (n_wr !== 256 || bad !== 0) begin
      errors++;
      $display("FAIL ovf_writes n=%0d bad=%0d exp=256 0", n_wr, bad);
    end
    checks++;
    if (err_o !== 1'b1 || word_count_o !== 9'd256) begin
      errors++;
      $display("FAIL ovf_hold err=%b count=%0d exp=1 256", err_o, word_count_o);
    end
    load_req_i = 1'b1;
    step();
    load_req_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || err_o !== 1'b0 || word_count_o !== 9'd0 || data_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_reload busy=%b err=%b count=%0d ready=%b exp=1 0 0 1", busy_o, err_o, word_count_o, data_ready_o);
    end
  endtask

  // Entered while already in LOAD with a zero count.
  task automatic test_reset_midload();
    n_wr = 0;
    for (int i = 0; i < 2; i++) begin
      data_valid_i = 1'b1;
      data_i = prog[i];
      data_last_i = 1'b0;
      step();
    end
    data_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({data_ready_o, imem_we_o, start_o, busy_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_flags got=%b exp=00000", {data_ready_o, imem_we_o, start_o, busy_o, err_o});
    end
    checks++;
    if (word_count_o !== 9'd0 || imem_addr_o !== 8'd0 || imem_data_o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_values count=%0d addr=%0d data=%h exp=0", word_count_o, imem_addr_o, imem_data_o);
    end
    #2;
    rst_i = 1'b1;
    step();
    checks++;
    if (n_wr !== 1 || busy_o !== 1'b0 || data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle writes=%0d busy=%b ready=%b exp=1 0 0", n_wr, busy_o, data_ready_o);
    end
    data_valid_i = 1'b1;
    data_i = 32'h1234_5678;
    repeat (2) step();
    data_valid_i = 1'b0;
    checks++;
    if (n_wr !== 1 || word_count_o !== 9'd0 || imem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid writes=%0d count=%0d we=%b exp=1 0 0", n_wr, word_count_o, imem_we_o);
    end
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      load_req_i = 1'b1;
      step();
      load_req_i = 1'b0;
      n_wr = 0;
      for (int i = 0; i < 4; i++) begin
        data_valid_i = 1'b1;
        data_i = (i < 3) ? 32'(i + 1) : ((pass == 0) ? 32'd6 : 32'd7);
        data_last_i = (i == 3);
        step();
      end
      data_valid_i = 1'b0;
      data_last_i = 1'b0;
      checks++;
      if (word_count_o !== 9'd3 || imem_we_o !== 1'b0 || start_o !== 1'b0) begin
        errors++;
        $display("FAIL csum_check pass=%0d count=%0d we=%b start=%b exp=3 0 0", pass, word_count_o, imem_we_o, start_o);
      end
      step();
      checks++;
      if (n_wr !== 3 || wr_data[2] !== 32'd3) begin
        errors++;
        $display("FAIL csum_writes pass=%0d n=%0d d2=%0d exp=3 3", pass, n_wr, wr_data[2]);
      end
      checks++;
      if (start_o !== (pass == 0) || err_o !== (pass == 1)) begin
        errors++;
        $display("FAIL csum_result pass=%0d start=%b err=%b", pass, start_o, err_o);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'h00000013;
    prog[1] = 32'h00500093;
    prog[2] = 32'h00A00113;
    test_reset();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_basic();
    test_stall();
    test_ignore_req();
`endif
    test_overflow();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
